// File: rtl/axis_frame_buffer.sv
// axis_frame_buffer: store-and-forward AXI-Stream frame buffer.
// Frames are released behind a {seq,len} header only once complete.
module axis_frame_buffer #(
    parameter int DEPTH_LOG2      = 11,
    parameter int MAX_FRAME_WORDS = 512
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic [31:0] s_tdata,
    input  logic [3:0]  s_tkeep,
    input  logic        s_tlast,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic [31:0] m_tdata,
    output logic [3:0]  m_tkeep,
    output logic        m_tlast,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [31:0] frame_count,
    output logic [31:0] drop_count
);
    localparam int         PW      = DEPTH_LOG2 + 1;
    localparam int         DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCEPT  = 2'd1;
    localparam logic [1:0] DISCARD = 2'd2;

    logic [36:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr_commit;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [1:0]    r_state;
    logic [16:0]   r_len;
    logic [15:0]   r_seq;
    logic [31:0]   r_frame_count;
    logic [31:0]   r_drop_count;
    logic          r_s_tready;
    logic [36:0]   r_rdata;
    logic          r_rvld;
    logic [1:0]    r_cnt;
    logic [36:0]   r_q0;
    logic [36:0]   r_q1;

    logic          w_beat;
    logic          w_fits;
    logic          w_over;
    logic          w_drop;
    logic [16:0]   w_len_nx;
    logic [16:0]   w_flen;
    logic [PW-1:0] w_used;
    logic [PW:0]   w_free;
    logic          w_dwe;
    logic          w_hwe;
    logic [PW-1:0] w_daddr;
    logic [36:0]   w_hdr;
    logic          w_pop;
    logic          w_rd_en;
    logic [1:0]    w_occ;

    assign w_beat   = s_tvalid & r_s_tready;
    assign w_used   = r_wr_commit - r_rd_ptr;
    assign w_free   = (PW+1)'(DEPTH) - {1'b0, w_used};
    assign w_fits   = w_free >= (PW+1)'(MAX_FRAME_WORDS + 1);
    assign w_len_nx = r_len + 17'd1;
    assign w_over   = w_len_nx > 17'(MAX_FRAME_WORDS);
    assign w_hdr    = {1'b0, 4'hF, r_seq, w_flen[15:0]};
    assign w_drop   = w_beat & s_tlast & ~w_hwe;

    // A header write is exactly a frame commit.
    always_comb begin
        w_dwe   = 1'b0;
        w_hwe   = 1'b0;
        w_daddr = r_wr_ptr;
        w_flen  = w_len_nx;
        unique case (r_state)
            IDLE: begin
                w_daddr = r_wr_commit + PW'(1);
                w_flen  = 17'd1;
                w_dwe   = w_beat & w_fits;
                w_hwe   = w_beat & w_fits & s_tlast;
            end
            ACCEPT: begin
                w_dwe = w_beat & ~w_over;
                w_hwe = w_beat & ~w_over & s_tlast;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_dwe)
            r_mem[w_daddr[PW-2:0]] <= {s_tlast, s_tkeep, s_tdata};
        if (w_hwe)
            r_mem[r_wr_commit[PW-2:0]] <= w_hdr;
        if (w_rd_en)
            r_rdata <= r_mem[r_rd_ptr[PW-2:0]];
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_state       <= IDLE;
            r_wr_commit   <= '0;
            r_wr_ptr      <= '0;
            r_len         <= '0;
            r_seq         <= '0;
            r_frame_count <= '0;
            r_drop_count  <= '0;
            r_s_tready    <= 1'b0;
        end else begin
            r_s_tready <= 1'b1;
            if (w_hwe) begin
                r_wr_commit   <= r_wr_commit + PW'(w_flen) + PW'(1);
                r_frame_count <= r_frame_count + 32'd1;
            end
            if (w_drop)
                r_drop_count <= r_drop_count + 32'd1;
            if (w_beat && s_tlast) begin
                r_seq   <= r_seq + 16'd1;
                r_state <= IDLE;
            end else if (w_beat) begin
                unique case (r_state)
                    IDLE: begin
                        if (w_fits) begin
                            r_wr_ptr <= r_wr_commit + PW'(2);
                            r_len    <= 17'd1;
                            r_state  <= ACCEPT;
                        end else begin
                            r_state <= DISCARD;
                        end
                    end
                    ACCEPT: begin
                        if (w_over) begin
                            r_state <= DISCARD;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + PW'(1);
                            r_len    <= w_len_nx;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Reads keep memory-output plus skid entries at most two deep.
    assign w_pop   = (r_cnt != 2'd0) & m_tready;
    assign w_occ   = r_cnt + {1'b0, r_rvld};
    assign w_rd_en = (r_rd_ptr != r_wr_commit) & ((w_occ < 2'd2) | w_pop);

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_rd_ptr <= '0;
            r_rvld   <= 1'b0;
            r_cnt    <= 2'd0;
            r_q0     <= '0;
            r_q1     <= '0;
        end else begin
            r_rvld <= w_rd_en;
            if (w_rd_en)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            unique case (r_cnt)
                2'd0: begin
                    if (r_rvld) begin
                        r_q0  <= r_rdata;
                        r_cnt <= 2'd1;
                    end
                end
                2'd1: begin
                    if (r_rvld && w_pop) begin
                        r_q0 <= r_rdata;
                    end else if (r_rvld) begin
                        r_q1  <= r_rdata;
                        r_cnt <= 2'd2;
                    end else if (w_pop) begin
                        r_cnt <= 2'd0;
                    end
                end
                default: begin
                    if (w_pop) begin
                        r_q0 <= r_q1;
                        if (r_rvld)
                            r_q1 <= r_rdata;
                        else
                            r_cnt <= 2'd1;
                    end
                end
            endcase
        end
    end

    assign s_tready    = r_s_tready;
    assign m_tvalid    = r_cnt != 2'd0;
    assign m_tdata     = r_q0[31:0];
    assign m_tkeep     = r_q0[35:32];
    assign m_tlast     = r_q0[36];
    assign frame_count = r_frame_count;
    assign drop_count  = r_drop_count;
endmodule

// File: doc/axis_frame_buffer.md
# axis_frame_buffer

Store-and-forward AXI-Stream frame buffer between the `stream_gen` source and the XDMA `stream_in` slave port. It holds whole frames and releases a frame downstream only after its last beat is received, so the DMA never sees a partial frame. It prepends a header word carrying a sequence number and length to every frame. When the buffer cannot hold a worst-case frame, the incoming frame is dropped whole, because the rate-driven source is never back-pressured.

## Interface
- `DEPTH_LOG2`, 11 — buffer depth is 2^DEPTH_LOG2 words of 37 bits (32 data, 4 keep, 1 last).
- `MAX_FRAME_WORDS`, 512 — largest accepted data-beat count per frame. Must satisfy MAX_FRAME_WORDS+1 ≤ 2^DEPTH_LOG2 and MAX_FRAME_WORDS ≤ 65535.
- `clk`  in  1  single clock domain; all logic is on the rising edge.
- `aresetn`  in  1  synchronous, active-low reset.
- `s_tdata`  in  32  input data from the source.
- `s_tkeep`  in  4  input byte enables; stored unchanged.
- `s_tlast`  in  1  last beat of the input frame.
- `s_tvalid`  in  1  input beat valid.
- `s_tready`  out  1  constant 1 out of reset, 0 during reset.
- `m_tdata`  out  32  output data to the DMA.
- `m_tkeep`  out  4  output byte enables; 4'hF on header beats.
- `m_tlast`  out  1  last data beat of the output frame.
- `m_tvalid`  out  1  output beat valid.
- `m_tready`  in  1  DMA ready.
- `frame_count`  out  32  count of committed frames; wraps.
- `drop_count`  out  32  count of dropped frames; wraps.

## Operation
- Pointers `wr_commit`, `wr_ptr` and `rd_ptr` are each DEPTH_LOG2+1 bits.
  - used = wr_commit − rd_ptr, computed modulo 2^(DEPTH_LOG2+1).
  - free = 2^DEPTH_LOG2 − used.
- Write FSM states: IDLE, ACCEPT, DISCARD.
- IDLE:
  - On the first beat of a frame (s_tvalid), evaluate free ≥ MAX_FRAME_WORDS+1.
  - If true: reserve the header slot at wr_commit, write the beat at wr_commit+1, set len=1, then go to ACCEPT.
  - If false: go to DISCARD with `drop_pending` set.
  - If the first beat also has tlast, it is a single-beat frame and the frame completes (commit or drop) in the same cycle; the FSM stays in IDLE.
- ACCEPT:
  - Each beat is written at the next address and len is incremented.
  - On tlast: write header {seq[15:0], len[15:0]} with keep 4'hF and last 0 into the reserved slot; advance wr_commit by len+1; increment frame_count; go to IDLE.
  - If a beat would make len > MAX_FRAME_WORDS: abandon the frame (wr_commit unchanged) and go to DISCARD.
- DISCARD:
  - Beats are consumed and not written.
  - On tlast: increment drop_count and go to IDLE.
- `seq` is 16 bits, reset to 0, and wraps. It increments once per input frame at its end, whether committed or dropped, so the consumer detects loss as a sequence gap.
- Read side:
  - Reads only while rd_ptr ≠ wr_commit.
  - Emits header, then the data beats. m_tlast comes from the stored last bit, so the header beat always has tlast 0.
  - Uses a synchronous-read memory with a 2-entry prefetch/skid stage, so m_* hold steady while m_tvalid=1 and m_tready=0.
- A commit and a read in the same cycle are both honored. Free space used for the admission check may be stale by the prefetch depth, which is conservative only.

## Timing
- Reset values: s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0, m_tkeep=0, frame_count=0, drop_count=0. Pointers, seq, len and FSM are cleared to IDLE.
- Reset asserted mid-frame discards all buffered and partial frames. No output beat follows until a new frame commits.
- Latency: the header is on m_* with m_tvalid=1 at most 3 edges after the edge accepting the input tlast.
- With m_tready held at 1, a committed frame of N beats streams as N+1 consecutive valid beats with no bubbles. Back-to-back committed frames also stream with no gap between them.
- AXI-S rule: once m_tvalid=1, m_tvalid and m_tdata/m_tkeep/m_tlast stay stable until m_tready=1.
- Empty buffer: m_tvalid=0. Full buffer: never back-pressures upstream and drops whole frames instead.

## Test plan
- Single frame: send 512 beats with data 0..511 and tlast on the last beat, m_tready=1.
  - Expect 513 beats: header 0x0000_0200, then 0..511, with m_tlast only on 511.
  - Expect frame_count=1.
- Back-pressure: m_tready=0 for 5 frames of 512 beats with DEPTH_LOG2=11.
  - Frames 1–3 commit; frame 4 is dropped (free 509 < 513) and drop_count=1.
  - Frame 5 is also dropped, so drop_count=2.
  - Release m_tready: headers appear with seq 0, 1, 2, and the consumer sees seq 3–4 missing only at the next commit.
- Oversize: a 600-beat frame, then a 4-beat frame.
  - drop_count=1; the output is only the header 0x0001_0004 plus 4 beats.
- Single-beat frame: tlast on the first beat, data 0xDEADBEEF.
  - Output is header 0x0000_0001, then 0xDEADBEEF with m_tlast=1.
- Random m_tready at 30% duty with continuous 16-beat frames.
  - Output data matches the input order exactly; m_* are stable during stalls.
  - seq increments by 1 per frame and wraps 0xFFFF→0x0000 after 65536 frames.
- Reset mid-frame: assert aresetn=0 for 1 cycle after 100 beats, then send one 8-beat frame.
  - Counters are 0 after reset; the only output is header 0x0000_0008 plus 8 beats.
